// File: rtl/multibyte_addsub_seq_if.sv
// ----------------------------------------------------------------------------
// multibyte_addsub_seq_if : start/busy/done handshake and operand/result bus
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface multibyte_addsub_seq_if #(
  parameter int BYTES = 4
) ();
  localparam int WIDTH = 8 * BYTES;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, op, a, b, cin,
    input  busy, done, result, cout, ovf, zero
  );

  modport slave (
    input  start, op, a, b, cin,
    output busy, done, result, cout, ovf, zero
  );
endinterface

`default_nettype wire

// File: rtl/multibyte_addsub_seq.sv
// ----------------------------------------------------------------------------
// multibyte_addsub_seq : BYTES x 8-bit add/sub, one byte per cycle, LSB first
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  input  logic       mode,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] b_op;
  logic       c_op;

  // mode=0 subtracts with its own +1, which ignores cin and so cannot chain
  assign b_op = mode ? b : ~b;
  assign c_op = mode ? cin : 1'b1;
  assign {cout, sum} = {1'b0, a} + {1'b0, b_op} + {8'b0, c_op};
endmodule

module multibyte_addsub_seq #(
  parameter int BYTES = 4,
  parameter int WIDTH = 8 * BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  multibyte_addsub_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] result_r;
  logic             op_lat;
  logic             carry;
  logic [2:0]       idx;
  logic             busy_r;
  logic             done_r;
  logic             cout_r;
  logic             ovf_r;

  logic [5:0] bit_base;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic [7:0] add_sum;
  logic       add_cout;
  logic       last_byte;

  assign bit_base  = {idx, 3'b000};
  assign add_a     = a_lat[bit_base +: 8];
  // Subtract as A + ~B + cin so the borrow travels through the carry register
  assign add_b     = op_lat ? b_lat[bit_base +: 8] : ~b_lat[bit_base +: 8];
  assign last_byte = (idx == 3'(BYTES - 1));

  adder_8bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry),
    .mode (1'b1),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_lat    <= '0;
      b_lat    <= '0;
      op_lat   <= 1'b0;
      carry    <= 1'b0;
      idx      <= 3'd0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_lat  <= bus.a;
            b_lat  <= bus.b;
            op_lat <= bus.op;
            carry  <= bus.cin;
            idx    <= 3'd0;
            busy_r <= 1'b1;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          result_r[bit_base +: 8] <= add_sum;
          carry                   <= add_cout;
          idx                     <= idx + 3'd1;
          if (last_byte) begin
            cout_r <= add_cout;
            ovf_r  <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
            busy_r <= 1'b0;
            done_r <= 1'b1;
            idx    <= 3'd0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.cout   = cout_r;
  assign bus.ovf    = ovf_r;
  assign bus.zero   = (result_r == '0);
endmodule

`default_nettype wire

// File: tb/tb_multibyte_addsub_seq.sv
// ----------------------------------------------------------------------------
// tb_multibyte_addsub_seq : directed self-checking bench, BYTES=4
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multibyte_addsub_seq;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   lat;
  int   bcnt;

  multibyte_addsub_seq_if #(.BYTES(4)) bus ();

  multibyte_addsub_seq #(.BYTES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait for done; lat counts edges including the start edge
  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input logic c, output int l, output int bc);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.b = bv; bus.cin = c;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l  = 1;
    bc = 0;
    while (!bus.done && l < 20) begin
      if (bus.busy) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = 1'b1; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   bus.busy,   0);
    chk("rst_done",   bus.done,   0);
    chk("rst_result", bus.result, 0);
    chk("rst_cout",   bus.cout,   0);
    chk("rst_ovf",    bus.ovf,    0);
    chk("rst_zero",   bus.zero,   1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b1, 32'h000000FF, 32'h00000001, 1'b0, lat, bcnt);
    chk("t1_latency", lat, 5);
    chk("t1_busycyc", bcnt, 4);
    chk("t1_busy_at_done", bus.busy, 0);
    chk("t1_result", bus.result, 64'h00000100);
    chk("t1_cout", bus.cout, 0);
    chk("t1_ovf",  bus.ovf,  0);
    chk("t1_zero", bus.zero, 0);
    @(posedge clk); #1;
    chk("t1_done_pulse", bus.done, 0);

    run_op(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bcnt);
    chk("t2_latency", lat, 5);
    chk("t2_result", bus.result, 64'h00000000);
    chk("t2_cout", bus.cout, 1);
    chk("t2_zero", bus.zero, 1);
    chk("t2_ovf",  bus.ovf,  0);
    @(posedge clk); #1;

    run_op(1'b0, 32'h80000000, 32'h00000001, 1'b1, lat, bcnt);
    chk("t3_result", bus.result, 64'h7FFFFFFF);
    chk("t3_cout", bus.cout, 1);
    chk("t3_ovf",  bus.ovf,  1);
    @(posedge clk); #1;

    run_op(1'b0, 32'h00000005, 32'h00000007, 1'b1, lat, bcnt);
    chk("t4_result", bus.result, 64'hFFFFFFFE);
    chk("t4_cout", bus.cout, 0);
    chk("t4_ovf",  bus.ovf,  0);
    @(posedge clk); #1;

    run_op(1'b1, 32'h7FFFFFFF, 32'h00000001, 1'b1, lat, bcnt);
    chk("t5_result", bus.result, 64'h80000001);
    chk("t5_ovf",  bus.ovf,  1);
    chk("t5_cout", bus.cout, 0);
    @(posedge clk); #1;

    // start pulsed mid-RUN with other operands must be ignored
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h1; bus.b = 32'h2; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h100; bus.b = 32'h100; bus.cin = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("t6_latency", lat, 5);
    chk("t6_result", bus.result, 64'h00000003);
    @(posedge clk); #1;

    // back-to-back: start held in the DONE cycle
    run_op(1'b1, 32'h0000000A, 32'h00000014, 1'b0, lat, bcnt);
    chk("t7a_done", bus.done, 1);
    chk("t7a_result", bus.result, 64'h0000001E);
    run_op(1'b1, 32'h00001000, 32'h00002000, 1'b0, lat, bcnt);
    chk("t7b_latency", lat, 5);
    chk("t7b_busycyc", bcnt, 4);
    chk("t7b_result", bus.result, 64'h00003000);
    @(posedge clk); #1;

    // asynchronous reset after byte 1 has been written
    bus.start = 1'b1; bus.op = 1'b1; bus.a = 32'h01020304; bus.b = 32'h01010101; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("t8_busy_before", bus.busy, 1);
    chk("t8_partial", bus.result, 64'h00000405);
    #2 rst = 1'b1;
    #1;
    chk("t8_busy",   bus.busy,   0);
    chk("t8_done",   bus.done,   0);
    chk("t8_result", bus.result, 0);
    chk("t8_cout",   bus.cout,   0);
    chk("t8_ovf",    bus.ovf,    0);
    chk("t8_zero",   bus.zero,   1);
    @(posedge clk); #1;
    rst = 1'b0;
    bcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) bcnt++;
    end
    chk("t8_no_done_after_abort", bcnt, 0);

    run_op(1'b1, 32'h01020304, 32'h01010101, 1'b0, lat, bcnt);
    chk("t9_latency", lat, 5);
    chk("t9_result", bus.result, 64'h02030405);
    chk("t9_cout", bus.cout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/multibyte_addsub_seq.md
# multibyte_addsub_seq

Multi-cycle sequencer that performs BYTES×8-bit add or subtract by time-sharing a single `adder_8bit` instance, one byte per cycle, LSB first, with the carry chained through a register. It sits in the ALU beside the 8-bit datapath and lets wide operands (address arithmetic, 16/32-bit counters) run through the existing byte adder without a wide carry chain. A start/busy/done handshake connects it to the CPU control unit.

## Interface

Parameters:
- BYTES, 4, operand width in bytes; legal 2..8.
- WIDTH, 8*BYTES, derived operand width; not overridden.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op  in  1  1 = add, 0 = subtract.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- cin  in  1  carry-in; for subtract, 1 = no borrow.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle pulse; result and flags valid.
- result  out  WIDTH  A+B+cin or A+~B+cin; held until next accepted start.
- cout  out  1  final carry out of MSB byte; for subtract, 1 = no borrow.
- ovf  out  1  signed two's-complement overflow.
- zero  out  1  result == 0.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 → latch a, b, op; carry register ← cin; byte index ← 0; go to RUN. start=0 → stay.
- RUN: adder driven with A = a_lat[8k+7:8k], B = op ? b_lat byte k : ~b_lat byte k, Cin = carry register, adder mode tied to 1 (add). Subtraction is done by inverting B here, not by the adder's own subtract mode; its internal +1 does not chain across bytes.
- Each RUN cycle: result byte k ← sum; carry register ← Cout; k ← k+1. When k = BYTES-1, go to DONE.
- At last byte: cout ← Cout; ovf ← (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is the inverted B for subtract.
- DONE: done=1 for exactly this cycle. start=1 → accept new operation exactly as in IDLE and go to RUN (back-to-back). start=0 → IDLE.
- start while in RUN: ignored, no queuing, latched operands unchanged.
- zero: combinational compare of the result register; meaningful when done=1 and after.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing

- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, zero=1; state IDLE; carry register 0; byte index 0.
- Reset mid-operation: immediate abort to IDLE, outputs to reset values, no done pulse.
- Latency: start sampled at edge 0; RUN occupies edges 1..BYTES; done high in the cycle after edge BYTES. Start-to-done = BYTES+1 edges (5 for BYTES=4).
- busy high in the cycles following edges 0..BYTES-1, low when done is high.
- Throughput with back-to-back starts: one result per BYTES+1 cycles.
- result bytes update progressively during RUN; consumers read them only when done=1 or later.
- All outputs registered except zero (combinational from result register).

## Test plan

- BYTES=4, add, a=0x000000FF, b=0x00000001, cin=0 → result=0x00000100, cout=0, ovf=0, zero=0; done exactly 5 edges after start, busy high for 4 cycles.
- Add, a=0xFFFFFFFF, b=0x00000001, cin=0 → result=0x00000000, cout=1, zero=1, ovf=0 (carry ripples through all four bytes).
- Subtract, a=0x80000000, b=0x00000001, cin=1 → result=0x7FFFFFFF, cout=1, ovf=1; subtract a=5, b=7, cin=1 → result=0xFFFFFFFE, cout=0, ovf=0.
- Add, a=0x7FFFFFFF, b=0x00000001, cin=1 → result=0x80000001, ovf=1, cout=0.
- start pulsed during RUN with different operands → ignored, first result unchanged; start held high in the DONE cycle → second operation begins with no IDLE gap, second done 5 edges later.
- rst asserted asynchronously mid-RUN (after byte 1) → busy, done, result, cout and ovf drop to 0 and zero goes to 1 without waiting for a clock edge; no done pulse; next start runs correctly from byte 0.
